// File: rtl/shared_memory_writer.sv
// Write side of the shared register file: two valid/ready clients, round-robin
// arbitration, one committed write per cycle into a banked register memory.

module shared_memory_entry #(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            q <= '0;
        else if (we)
            q <= d;
    end
endmodule

module shared_memory_writer #(
    parameter int DATA_WIDTH  = 2,
    parameter int ADDR_WIDTH  = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                               clock,
    input  logic                               clear_n,
    input  logic                               wr1_valid,
    input  logic [ADDR_WIDTH-1:0]              wr1_addr,
    input  logic [DATA_WIDTH-1:0]              wr1_data,
    output logic                               wr1_ready,
    input  logic                               wr2_valid,
    input  logic [ADDR_WIDTH-1:0]              wr2_addr,
    input  logic [DATA_WIDTH-1:0]              wr2_data,
    output logic                               wr2_ready,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] memory,
    output logic                               last_grant,
    output logic [COUNT_WIDTH-1:0]             write_count
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t req1, req2, win;
    logic    prio;   // 0 = client 1 wins a tie, 1 = client 2
    logic    gnt1, gnt2, xfer;

    assign req1 = '{addr: wr1_addr, data: wr1_data};
    assign req2 = '{addr: wr2_addr, data: wr2_data};

    // Readies are gated by clear_n so nothing looks granted while held in reset.
    assign gnt1 = clear_n & wr1_valid & (~wr2_valid | ~prio);
    assign gnt2 = clear_n & wr2_valid & (~wr1_valid |  prio);
    assign xfer = gnt1 | gnt2;
    assign win  = gnt2 ? req2 : req1;

    assign wr1_ready = gnt1;
    assign wr2_ready = gnt2;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            prio        <= 1'b0;
            last_grant  <= 1'b0;
            write_count <= '0;
        end else if (xfer) begin
            prio       <= gnt1;
            last_grant <= gnt2;
            if (write_count != {COUNT_WIDTH{1'b1}})
                write_count <= write_count + COUNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic we;
        assign we = xfer && (win.addr == ADDR_WIDTH'(g));
        shared_memory_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
            .clock   (clock),
            .clear_n (clear_n),
            .we      (we),
            .d       (win.data),
            .q       (memory[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_shared_memory_writer.sv
// Scoreboard bench for shared_memory_writer: expected transfers queued at drive
// time, retired against a reference memory/counter after each clock edge.

module tb_shared_memory_writer;
    localparam int DW = 2;
    localparam int AW = 2;
    localparam int CW = 8;
    localparam int MW = (2**AW)*DW;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          wr1_valid = 1'b0, wr2_valid = 1'b0;
    logic [AW-1:0] wr1_addr = '0, wr2_addr = '0;
    logic [DW-1:0] wr1_data = '0, wr2_data = '0;
    logic          wr1_ready, wr2_ready;
    logic [MW-1:0] memory;
    logic          last_grant;
    logic [CW-1:0] write_count;

    shared_memory_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .clear_n(clear_n),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .wr2_valid(wr2_valid), .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_ready(wr2_ready),
        .memory(memory), .last_grant(last_grant), .write_count(write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          g1, g2;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [MW-1:0] exp_mem;
    logic [CW-1:0] exp_cnt;
    logic          exp_lg, exp_ptr;
    exp_t          cur;
    int            vectors = 0;
    int            errors  = 0;

    task automatic model_reset();
        exp_mem = '0; exp_cnt = '0; exp_lg = 1'b0; exp_ptr = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of requests and enqueue the grant the arbiter must give.
    task automatic drive(input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        exp_t e;
        wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
        wr2_valid = v2; wr2_addr = a2; wr2_data = d2;
        e.g1 = v1 && (!v2 || !exp_ptr);
        e.g2 = v2 && (!v1 ||  exp_ptr);
        e.addr = e.g2 ? a2 : a1;
        e.data = e.g2 ? d2 : d1;
        sb.push_back(e);
        cur = e;
    endtask

    task automatic commit();
        exp_t e;
        e = sb.pop_front();
        if (e.g1 || e.g2) begin
            exp_mem[e.addr*DW +: DW] = e.data;
            exp_lg  = e.g2;
            exp_ptr = e.g1;
            if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic idle();
        wr1_valid = 1'b0; wr2_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        clear_n = 1'b0;
        model_reset();
        @(posedge clock); #1;
        clear_n = 1'b1;
    endtask

    task automatic test_reset_initial();
        do_reset();
        vectors++;
        if (memory !== '0 || write_count !== '0 || last_grant !== 1'b0)
            begin errors++; $display("FAIL reset_init mem=%h cnt=%0d lg=%b want 0", memory, write_count, last_grant); end
    endtask

    task automatic test_single();
        drive(1, 2, 2'b11, 0, 0, 0);
        @(negedge clock); vectors++;
        if ({wr1_ready, wr2_ready} !== {cur.g1, cur.g2})
            begin errors++; $display("FAIL single_rdy0 got %b%b want %b%b", wr1_ready, wr2_ready, cur.g1, cur.g2); end
        @(posedge clock); #1; commit();
        drive(1, 0, 2'b01, 0, 0, 0);
        @(negedge clock); vectors++;
        if ({wr1_ready, wr2_ready} !== {cur.g1, cur.g2})
            begin errors++; $display("FAIL single_rdy1 got %b%b want %b%b", wr1_ready, wr2_ready, cur.g1, cur.g2); end
        @(posedge clock); #1; commit(); idle();
        vectors++;
        if (memory !== 8'b0011_0001 || memory !== exp_mem)
            begin errors++; $display("FAIL single_mem got %b want %b", memory, exp_mem); end
        vectors++;
        if (write_count !== 8'd2 || last_grant !== 1'b0)
            begin errors++; $display("FAIL single_cnt got cnt=%0d lg=%b want 2/0", write_count, last_grant); end
    endtask

    task automatic test_contention();
        logic [1:0] want_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 2'b01, 1, 3, 2'b10);
            @(negedge clock); vectors++;
            if ({wr1_ready, wr2_ready} !== {cur.g1, cur.g2} || {wr1_ready, wr2_ready} !== want_rdy[i])
                begin errors++; $display("FAIL cont_rdy%0d got %b%b want %b", i, wr1_ready, wr2_ready, want_rdy[i]); end
            @(posedge clock); #1; commit();
            vectors++;
            if (last_grant !== exp_lg || last_grant !== want_rdy[i][0] || memory !== exp_mem)
                begin errors++; $display("FAIL cont_lg%0d got lg=%b mem=%b want lg=%b mem=%b", i, last_grant, memory, exp_lg, exp_mem); end
        end
        idle();
        vectors++;
        if (write_count !== 8'd4 || memory[3:2] !== 2'b01 || memory[7:6] !== 2'b10)
            begin errors++; $display("FAIL cont_final got cnt=%0d mem=%b want cnt=4 mem[3:2]=01 mem[7:6]=10", write_count, memory); end
    endtask

    task automatic test_reset_async();
        // memory is nonzero here; reset must clear it with no clock edge.
        drive(1, 2, 2'b11, 1, 1, 2'b10);
        #2 clear_n = 1'b0;
        #1; vectors++;
        if (memory !== '0 || write_count !== '0 || last_grant !== 1'b0 || wr1_ready !== 1'b0 || wr2_ready !== 1'b0)
            begin errors++; $display("FAIL reset_async mem=%h cnt=%0d lg=%b rdy=%b%b want all 0", memory, write_count, last_grant, wr1_ready, wr2_ready); end
        @(posedge clock); #1;
        vectors++;
        if (memory !== '0 || write_count !== '0)
            begin errors++; $display("FAIL reset_hold mem=%h cnt=%0d want 0", memory, write_count); end
        do_reset();
    endtask

    task automatic test_collision();
        do_reset();
        drive(1, 0, 2'b01, 1, 0, 2'b10);
        @(negedge clock); vectors++;
        if ({wr1_ready, wr2_ready} !== 2'b10)
            begin errors++; $display("FAIL coll_first got %b%b want 10", wr1_ready, wr2_ready); end
        @(posedge clock); #1; commit();
        drive(0, 0, 2'b01, 1, 0, 2'b10);
        @(negedge clock); vectors++;
        if ({wr1_ready, wr2_ready} !== 2'b01)
            begin errors++; $display("FAIL coll_second got %b%b want 01", wr1_ready, wr2_ready); end
        @(posedge clock); #1; commit(); idle();
        vectors++;
        if (memory[1:0] !== 2'b10 || memory !== exp_mem)
            begin errors++; $display("FAIL coll_final got mem=%b want %b", memory, exp_mem); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(0, 0, 0, 1, AW'(i), DW'(i));
            @(negedge clock); vectors++;
            if (wr2_ready !== 1'b1 || wr1_ready !== 1'b0)
                begin errors++; $display("FAIL sat_rdy%0d got %b%b want 01", i, wr1_ready, wr2_ready); end
            @(posedge clock); #1; commit();
            vectors++;
            if (write_count !== exp_cnt || memory !== exp_mem)
                begin errors++; $display("FAIL sat_cnt%0d got cnt=%0d mem=%h want cnt=%0d mem=%h", i, write_count, memory, exp_cnt, exp_mem); end
        end
        idle();
        vectors++;
        if (write_count !== 8'd255 || last_grant !== 1'b1)
            begin errors++; $display("FAIL sat_final got cnt=%0d lg=%b want 255/1", write_count, last_grant); end
    endtask

    task automatic test_reset_during_transfer();
        do_reset();
        // Move the pointer to client 2 so the post-reset win by client 1 is meaningful.
        drive(1, 0, 2'b01, 0, 0, 0);
        @(posedge clock); #1; commit();
        drive(1, 1, 2'b11, 0, 0, 0);
        #2; vectors++;
        if (wr1_ready !== 1'b1)
            begin errors++; $display("FAIL rdt_rdy got %b want 1", wr1_ready); end
        clear_n = 1'b0;
        model_reset();
        @(posedge clock); #1;
        vectors++;
        if (memory[3:2] !== 2'b00 || memory !== '0 || write_count !== '0)
            begin errors++; $display("FAIL rdt_nocommit got mem=%b cnt=%0d want 0", memory, write_count); end
        clear_n = 1'b1;
        drive(1, 2, 2'b10, 1, 3, 2'b01);
        @(negedge clock); vectors++;
        if ({wr1_ready, wr2_ready} !== 2'b10 || {wr1_ready, wr2_ready} !== {cur.g1, cur.g2})
            begin errors++; $display("FAIL rdt_first got %b%b want 10", wr1_ready, wr2_ready); end
        @(posedge clock); #1; commit(); idle();
        vectors++;
        if (memory !== exp_mem || write_count !== 8'd1 || last_grant !== 1'b0)
            begin errors++; $display("FAIL rdt_commit got mem=%b cnt=%0d lg=%b want %b/1/0", memory, write_count, last_grant, exp_mem); end
    endtask

    initial begin
        model_reset();
        test_reset_initial();
        test_single();
        test_contention();
        test_reset_async();
        test_collision();
        test_saturation();
        test_reset_during_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shared_memory_writer.md
# shared_memory_writer

Write-side counterpart of the shared memory register file. It accepts write requests from two independent clients over valid/ready handshakes and arbitrates between them round-robin. Granted writes are committed into a banked register memory whose full contents are exported for the read side. The block sits in front of the storage and is the only agent that modifies it.

## Interface
Parameters:
- DATA_WIDTH, 2, bits per memory entry
- ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH entries
- COUNT_WIDTH, 8, width of the saturating write counter

Ports:
- clock  input  1  single clock; all state updates on posedge
- clear_n  input  1  asynchronous, active-low reset
- wr1_valid  input  1  client 1 request
- wr1_addr  input  ADDR_WIDTH  client 1 target entry
- wr1_data  input  DATA_WIDTH  client 1 write data
- wr1_ready  output  1  client 1 grant; a transfer occurs when wr1_valid && wr1_ready
- wr2_valid, wr2_addr, wr2_data, wr2_ready  same widths and meaning as client 1, for client 2
- memory  output  DEPTH*DATA_WIDTH  registered contents; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- last_grant  output  1  client of the most recent transfer (0 = client 1, 1 = client 2)
- write_count  output  COUNT_WIDTH  number of committed writes, saturating

## Operation
- Clock and reset are fixed: one clock (clock); reset (clear_n) is asynchronous and active-low.
- Reset (clear_n low, asynchronous):
  - memory = 0, last_grant = 0, write_count = 0.
  - Priority pointer = client 1.
  - wr1_ready = wr2_ready = 0 for as long as clear_n is low.
- Arbitration (combinational from valids and the priority pointer):
  - Only wrN_valid high: wrN_ready = 1.
  - Both high: the client named by the priority pointer gets ready = 1; the other gets 0.
  - Neither high: both ready = 0.
  - At most one ready is high in any cycle.
- Priority pointer:
  - After every transfer it points to the client that did not transfer.
  - With no transfer it holds.
  - A lone requester is always granted regardless of the pointer. The pointer still updates after that transfer.
- Commit on the transfer edge:
  - memory entry addr <= data.
  - last_grant <= granted client.
  - write_count increments, holding at 2**COUNT_WIDTH-1.
- Client rules:
  - Once valid is asserted, the client holds valid, addr and data stable until ready.
  - A denied client keeps waiting. It is guaranteed a grant in the next cycle, because the pointer has moved to it.
- Both clients writing the same address: the writes serialize in grant order. The later grant's data is the final value.
- Writes to entries other than addr leave those entries unchanged.

## Timing
- Grant latency: 0 cycles. Ready is asserted in the same cycle as valid when that client is granted.
- Write-to-memory latency: 1 edge. memory reflects a transfer immediately after the clock edge that samples it.
- Throughput: one write per cycle in total. Under continuous contention the clients alternate 1,2,1,2…, starting from the pointer value.
- Reset mid-transfer: if clear_n falls in a cycle where valid && ready, no commit occurs. All state returns to reset values asynchronously.
- Reset deassertion: the first transfer is possible on the first posedge after clear_n rises. Client 1 wins the first contention.
- No combinational path from any input to memory, last_grant or write_count.

## Test plan
- Reset: drive clear_n low mid-simulation with both valids high.
  - Required: memory = 0, write_count = 0, last_grant = 0, both ready = 0, with no clock edge needed.
- Single client:
  - Stimulus: wr1 writes addr 2 data 2'b11, then addr 0 data 2'b01.
  - Required: memory = 8'b0011_0001 after the second edge; write_count = 2; last_grant = 0.
- Contention:
  - Stimulus: both valid for 4 cycles; wr1 → addr 1 data 1, wr2 → addr 3 data 2.
  - Required grants: 1,2,1,2; last_grant 0,1,0,1; write_count = 4; memory[3:2] = 01; memory[7:6] = 10.
- Same-address collision, starting from reset:
  - Stimulus: both clients target addr 0; wr1 data 01, wr2 data 10.
  - Required: wr1 granted first and wr2 next cycle; final entry 0 = 10.
- Saturation:
  - Stimulus: 260 back-to-back wr2 writes.
  - Required: write_count stops at 255; wr2_ready stays high every cycle.
- Reset during transfer:
  - Stimulus: clear_n falls between edges while wr1_valid && wr1_ready (addr 1 data 11).
  - Required: entry 1 stays 00; after release, wr1 wins the next contention.
